// File: rtl/multimode_counter_if.sv
// Control/status bundle for multimode_counter: step controls in, count/flags out.
interface multimode_counter_if #(
   parameter int WIDTH = 8
) ();
   logic             en;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up_dn;
   logic [1:0]       mode;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;

   modport master (
      output en, clear, load, load_val, up_dn, mode, t_vec,
      input  q, tc, ovf
   );

   modport slave (
      input  en, clear, load, load_val, up_dn, mode, t_vec,
      output q, tc, ovf
   );
endinterface

// File: rtl/multimode_counter.sv
// WIDTH-bit binary/Gray modulo counter and T-register with prescaler and terminal-count pulse.
// Define MULTIMODE_COUNTER_OVF_STICKY_EN to build the sticky overflow flag; otherwise ovf is tied low.
module multimode_counter #(
   parameter int WIDTH    = 8,
   parameter int MODULO   = 256,
   parameter int PRESCALE = 1
) (
   input logic                 clk,
   input logic                 reset,
   multimode_counter_if.slave  bus
);

   localparam logic [1:0] MODE_BIN  = 2'b00;
   localparam logic [1:0] MODE_GRAY = 2'b01;
   localparam logic [1:0] MODE_TOG  = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PSC_LAST = PW'(PRESCALE - 1);
   // Wrap limits are one bit wider than cnt so MODULO == 2**WIDTH stays representable.
   localparam logic [WIDTH:0]  MOD_W    = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH:0]  LAST_W   = MOD_W - 1'b1;

   logic [WIDTH-1:0] cnt, cnt_next;
   logic [PW-1:0]    psc, psc_next;
   logic [WIDTH-1:0] q_r, q_next;
   logic             tc_r, tc_next;
   logic [WIDTH:0]   cnt_w;

   assign cnt_w = {1'b0, cnt};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cnt_next = cnt;
      psc_next = psc;
      tc_next  = 1'b0;
      if (bus.clear) begin
         cnt_next = '0;
         psc_next = '0;
      end else if (bus.load) begin
         cnt_next = bus.load_val;
         psc_next = '0;
      end else if (bus.en) begin
         case (bus.mode)
            MODE_BIN, MODE_GRAY: begin
               if (psc == PSC_LAST) begin
                  psc_next = '0;
                  if (bus.up_dn) begin
                     // Out-of-range values wrap to 0 on an up step just like MODULO-1.
                     if (cnt_w >= LAST_W) begin
                        cnt_next = '0;
                        tc_next  = 1'b1;
                     end else begin
                        cnt_next = cnt + 1'b1;
                     end
                  end else begin
                     if (cnt_w == '0) begin
                        cnt_next = LAST_W[WIDTH-1:0];
                        tc_next  = 1'b1;
                     end else if (cnt_w >= MOD_W) begin
                        cnt_next = LAST_W[WIDTH-1:0];
                     end else begin
                        cnt_next = cnt - 1'b1;
                     end
                  end
               end else begin
                  psc_next = psc + 1'b1;
               end
            end
            MODE_TOG:  cnt_next = cnt ^ bus.t_vec;
            MODE_HOLD: begin
            end
         endcase
      end
   end

   // q is encoded from the next state, so it tracks cnt with no extra latency.
   assign q_next = (bus.mode == MODE_GRAY) ? (cnt_next ^ (cnt_next >> 1)) : cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         cnt  <= '0;
         psc  <= '0;
         q_r  <= '0;
         tc_r <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         psc  <= psc_next;
         q_r  <= q_next;
         tc_r <= tc_next;
      end
   end

   assign bus.q  = q_r;
   assign bus.tc = tc_r;

`ifdef MULTIMODE_COUNTER_OVF_STICKY_EN
   logic ovf_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (bus.clear) begin
         ovf_r <= 1'b0;
      end else if (tc_next) begin
         ovf_r <= 1'b1;
      end
   end

   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multimode_counter.sv
// Directed self-checking bench for multimode_counter across three parameter sets.
module tb_multimode_counter;

`ifdef MULTIMODE_COUNTER_OVF_STICKY_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   localparam logic [3:0] GRAY_SEQ [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                            4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   multimode_counter_if #(.WIDTH(8)) bus_a ();
   multimode_counter_if #(.WIDTH(8)) bus_p ();
   multimode_counter_if #(.WIDTH(4)) bus_g ();

   multimode_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(1)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   multimode_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(3)) dut_p (
      .clk(clk), .reset(reset), .bus(bus_p)
   );
   multimode_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) dut_g (
      .clk(clk), .reset(reset), .bus(bus_g)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus_a.en = 0; bus_a.clear = 0; bus_a.load = 0; bus_a.load_val = '0;
      bus_a.up_dn = 1; bus_a.mode = 2'b00; bus_a.t_vec = '0;
      bus_p.en = 0; bus_p.clear = 0; bus_p.load = 0; bus_p.load_val = '0;
      bus_p.up_dn = 1; bus_p.mode = 2'b00; bus_p.t_vec = '0;
      bus_g.en = 0; bus_g.clear = 0; bus_g.load = 0; bus_g.load_val = '0;
      bus_g.up_dn = 1; bus_g.mode = 2'b00; bus_g.t_vec = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_all();
      pulse_reset();
      bus_a.en = 1;
      for (int i = 0; i < 5; i++) tick();
      n_tests++;
      if (bus_a.q !== 8'd5) begin
         n_fail++; $display("FAIL reset_precount q=%0d exp=5", bus_a.q);
      end
      reset = 1'b1;
      #2;
      n_tests++;
      if (bus_a.q !== 8'd0 || bus_a.tc !== 1'b0 || bus_a.ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_async q=%0d tc=%b ovf=%b exp q=0 tc=0 ovf=0", bus_a.q, bus_a.tc, bus_a.ovf);
      end
      n_tests++;
      if (bus_p.q !== 8'd0 || bus_g.q !== 4'd0) begin
         n_fail++; $display("FAIL reset_all qp=%0d qg=%0d exp 0", bus_p.q, bus_g.q);
      end
      bus_a.en = 0;
      reset = 1'b0;
   endtask

   task automatic test_up_count();
      logic [7:0] exp_q;
      logic       exp_tc;
      idle_all();
      pulse_reset();
      bus_a.en = 1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_q  = 8'(i % 10);
         exp_tc = (i == 10);
         n_tests++;
         if (bus_a.q !== exp_q || bus_a.tc !== exp_tc) begin
            n_fail++; $display("FAIL up_count step=%0d q=%0d tc=%b exp q=%0d tc=%b", i, bus_a.q, bus_a.tc, exp_q, exp_tc);
         end
      end
      bus_a.en = 0;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd0 || bus_a.tc !== 1'b0 || bus_a.ovf !== OVF_ON) begin
         n_fail++; $display("FAIL up_after_wrap q=%0d tc=%b ovf=%b exp q=0 tc=0 ovf=%b", bus_a.q, bus_a.tc, bus_a.ovf, OVF_ON);
      end
   endtask

   task automatic test_down_load();
      idle_all();
      pulse_reset();
      bus_a.load = 1; bus_a.load_val = 8'd0;
      tick();
      bus_a.load = 0; bus_a.up_dn = 0; bus_a.en = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd9 || bus_a.tc !== 1'b1) begin
         n_fail++; $display("FAIL down_wrap q=%0d tc=%b exp q=9 tc=1", bus_a.q, bus_a.tc);
      end
      tick();
      n_tests++;
      if (bus_a.q !== 8'd8 || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL down_step q=%0d tc=%b exp q=8 tc=0", bus_a.q, bus_a.tc);
      end
      bus_a.en = 0; bus_a.load = 1; bus_a.load_val = 8'd12;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd12 || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL load_oor q=%0d tc=%b exp q=12 tc=0", bus_a.q, bus_a.tc);
      end
      bus_a.load = 0; bus_a.up_dn = 1; bus_a.en = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd0 || bus_a.tc !== 1'b1) begin
         n_fail++; $display("FAIL up_from_oor q=%0d tc=%b exp q=0 tc=1", bus_a.q, bus_a.tc);
      end
      bus_a.en = 0; bus_a.load = 1; bus_a.load_val = 8'd12;
      tick();
      bus_a.load = 0; bus_a.up_dn = 0; bus_a.en = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd9 || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL down_from_oor q=%0d tc=%b exp q=9 tc=0", bus_a.q, bus_a.tc);
      end
      bus_a.en = 0; bus_a.load = 1; bus_a.load_val = 8'd3;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd3 || bus_a.ovf !== OVF_ON) begin
         n_fail++; $display("FAIL ovf_after_load q=%0d ovf=%b exp q=3 ovf=%b", bus_a.q, bus_a.ovf, OVF_ON);
      end
      bus_a.load = 0;
   endtask

   task automatic test_prescaler();
      logic [7:0] exp_q;
      bit         en_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] q_seq  [5] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
      idle_all();
      pulse_reset();
      bus_p.en = 1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         exp_q = 8'(i / 3);
         n_tests++;
         if (bus_p.q !== exp_q) begin
            n_fail++; $display("FAIL psc_run cycle=%0d q=%0d exp=%0d", i, bus_p.q, exp_q);
         end
      end
      for (int i = 0; i < 5; i++) begin
         bus_p.en = en_seq[i];
         tick();
         n_tests++;
         if (bus_p.q !== q_seq[i]) begin
            n_fail++; $display("FAIL psc_gap idx=%0d q=%0d exp=%0d", i, bus_p.q, q_seq[i]);
         end
      end
      bus_p.en = 1;
      tick();
      bus_p.en = 0; bus_p.load = 1; bus_p.load_val = 8'd7;
      tick();
      bus_p.load = 0; bus_p.en = 1;
      tick();
      tick();
      n_tests++;
      if (bus_p.q !== 8'd7) begin
         n_fail++; $display("FAIL psc_load_phase_early q=%0d exp=7", bus_p.q);
      end
      tick();
      n_tests++;
      if (bus_p.q !== 8'd8) begin
         n_fail++; $display("FAIL psc_load_phase q=%0d exp=8", bus_p.q);
      end
      bus_p.en = 0;
   endtask

   task automatic test_gray();
      logic [3:0] prev;
      logic       exp_tc;
      idle_all();
      pulse_reset();
      bus_g.mode = 2'b01; bus_g.en = 1;
      prev = 4'd0;
      for (int i = 0; i < 16; i++) begin
         tick();
         exp_tc = (i == 15);
         n_tests++;
         if (bus_g.q !== GRAY_SEQ[i] || bus_g.tc !== exp_tc || $countones(bus_g.q ^ prev) != 1) begin
            n_fail++; $display("FAIL gray step=%0d q=%h tc=%b prev=%h exp q=%h tc=%b", i + 1, bus_g.q, bus_g.tc, prev, GRAY_SEQ[i], exp_tc);
         end
         prev = bus_g.q;
      end
      bus_g.en = 0; bus_g.load = 1; bus_g.load_val = 4'd5;
      tick();
      n_tests++;
      if (bus_g.q !== 4'd7) begin
         n_fail++; $display("FAIL gray_load q=%h exp=7", bus_g.q);
      end
      bus_g.load = 0; bus_g.mode = 2'b00;
      tick();
      n_tests++;
      if (bus_g.q !== 4'd5 || bus_g.tc !== 1'b0) begin
         n_fail++; $display("FAIL mode_to_bin q=%h tc=%b exp q=5 tc=0", bus_g.q, bus_g.tc);
      end
      bus_g.mode = 2'b01;
      tick();
      n_tests++;
      if (bus_g.q !== 4'd7) begin
         n_fail++; $display("FAIL mode_to_gray q=%h exp=7", bus_g.q);
      end
   endtask

   task automatic test_toggle();
      idle_all();
      pulse_reset();
      bus_a.mode = 2'b10; bus_a.load = 1; bus_a.load_val = 8'hA5;
      tick();
      bus_a.load = 0; bus_a.t_vec = 8'h0F; bus_a.en = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'hAA || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL toggle_1 q=%h tc=%b exp q=aa tc=0", bus_a.q, bus_a.tc);
      end
      tick();
      n_tests++;
      if (bus_a.q !== 8'hA5 || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL toggle_2 q=%h tc=%b exp q=a5 tc=0", bus_a.q, bus_a.tc);
      end
      bus_a.t_vec = 8'h00;
      tick();
      n_tests++;
      if (bus_a.q !== 8'hA5) begin
         n_fail++; $display("FAIL toggle_zero q=%h exp=a5", bus_a.q);
      end
      bus_a.t_vec = 8'hFF; bus_a.mode = 2'b11;
      tick();
      n_tests++;
      if (bus_a.q !== 8'hA5 || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL mode_hold q=%h tc=%b exp q=a5 tc=0", bus_a.q, bus_a.tc);
      end
      bus_a.en = 0;
   endtask

   task automatic test_priority();
      idle_all();
      pulse_reset();
      bus_a.load = 1; bus_a.load_val = 8'd3;
      tick();
      bus_a.clear = 1; bus_a.load_val = 8'd7; bus_a.en = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd0 || bus_a.tc !== 1'b0) begin
         n_fail++; $display("FAIL clear_priority q=%0d tc=%b exp q=0 tc=0", bus_a.q, bus_a.tc);
      end
      bus_a.clear = 0;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd7) begin
         n_fail++; $display("FAIL load_over_en q=%0d exp=7", bus_a.q);
      end
      bus_a.load_val = 8'd9; bus_a.en = 0;
      tick();
      bus_a.load = 0; bus_a.en = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd0 || bus_a.tc !== 1'b1) begin
         n_fail++; $display("FAIL prio_wrap q=%0d tc=%b exp q=0 tc=1", bus_a.q, bus_a.tc);
      end
      bus_a.en = 0; bus_a.load = 1; bus_a.load_val = 8'd4;
      tick();
      bus_a.load_val = 8'd6;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd6 || bus_a.ovf !== OVF_ON) begin
         n_fail++; $display("FAIL ovf_sticky q=%0d ovf=%b exp q=6 ovf=%b", bus_a.q, bus_a.ovf, OVF_ON);
      end
      bus_a.load = 0; bus_a.clear = 1;
      tick();
      n_tests++;
      if (bus_a.q !== 8'd0 || bus_a.ovf !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear q=%0d ovf=%b exp q=0 ovf=0", bus_a.q, bus_a.ovf);
      end
      bus_a.clear = 0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      idle_all();
      #3;
      reset   = 1'b0;
      tick();
      test_reset();
      test_up_count();
      test_down_load();
      test_prescaler();
      test_gray();
      test_toggle();
      test_priority();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
- Parametrised successor to the team's single-bit toggle flip-flop: a WIDTH-bit register whose bits can toggle under per-bit control or advance as a modulo counter.
- Supports binary up/down count, Gray-coded count and T-register (per-bit toggle) modes, with an enable prescaler, synchronous load/clear and a terminal-count pulse.
- Used as the general counting/toggling primitive for timers, divider chains and lab state registers.

Parameters:
- WIDTH, 8, width of count register and output.
- MODULO, 256, count wraps at MODULO-1 ↔ 0; legal range 2..2^WIDTH.
- PRESCALE, 1, number of enabled cycles per count step in modes 00/01; legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  advance enable (count or toggle).
- clear  input  1  synchronous clear, highest synchronous priority.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value loaded on load.
- up_dn  input  1  1 = count up, 0 = count down (modes 00/01).
- mode  input  2  00 binary, 01 Gray, 10 T-register, 11 hold.
- t_vec  input  WIDTH  per-bit toggle mask, mode 10 only.
- q  output  WIDTH  registered output.
- tc  output  1  registered 1-cycle terminal-count pulse.
- ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-high, on clk: cnt=0, prescaler=0, q=0, tc=0, ovf=0. Mid-operation reset aborts immediately; the first update after release occurs on the first qualifying edge.
- State: binary register cnt[WIDTH-1:0]; prescaler counter psc sized to hold PRESCALE-1.
- Per-edge priority: clear > load > en-step > hold.
- clear: cnt=0, psc=0, tc=0. Also clears ovf when the feature is built.
- load: cnt=load_val, psc=0, tc=0. Any value is accepted, including values ≥MODULO.
- en-step in mode 00/01:
  - psc increments each en cycle.
  - When psc==PRESCALE-1: psc returns to 0 and cnt takes one step. With PRESCALE=1, cnt steps on every en cycle.
  - Up step: cnt==MODULO-1, or cnt≥MODULO, gives cnt=0 and tc=1. Otherwise cnt+1.
  - Down step: cnt==0 gives cnt=MODULO-1 and tc=1. cnt≥MODULO gives MODULO-1 with tc=0. Otherwise cnt-1.
- en-step in mode 10: cnt = cnt ^ t_vec on every en cycle. No prescaler, psc held, tc=0. t_vec=0 holds cnt.
- Mode 11, or en=0: cnt, psc held; tc=0.
- tc is high for exactly the one cycle following the wrapping edge.
- q output:
  - Registered on the same edge as cnt, from next-state values.
  - Mode 01: q = cnt_next ^ (cnt_next>>1).
  - All other modes: q = cnt_next.
  - So q reflects a step one cycle after the stimulus edge (zero extra latency versus cnt).
- Mode change: cnt is preserved. q is re-encoded on the next edge even when en=0; the mode change alone causes no step.
- Arithmetic: all wrap math is done WIDTH+1 bits wide, so MODULO=2^WIDTH is handled without overflow.

Optional Feature:
- Macro: MULTIMODE_COUNTER_OVF_STICKY_EN.
- Defined: ovf sets on any edge where tc is asserted (any wrap, up or down), and stays set until clear or reset. load does not clear it.
- Undefined: the ovf port still exists and is tied to constant 0; no storage is inferred.

Test Plan:
- Reset/basic up count: reset pulse mid-count with cnt=5 -> q=0 asynchronously; mode=00, up_dn=1, en=1, MODULO=10 -> q sequence 1..9,0, with tc=1 only in the cycle q returns to 0.
- Down wrap plus load out of range: load_val=0, down -> q=9, tc=1; load_val=12 (≥MODULO), up step -> q=0, tc=1; load 12, down step -> q=9, tc=0.
- Prescaler: PRESCALE=3, en=1 for 9 cycles from 0 -> q steps to 1,2,3 on cycles 3,6,9; en low for 2 cycles mid-sequence delays those steps by 2; load resets phase.
- Gray mode: mode=01, up from 0 with WIDTH=4, MODULO=16 -> q = 0,1,3,2,6,7,5,4,…,8,0; exactly one bit changes per step including the wrap 15→0.
- T-register: mode=10, cnt=8'hA5, t_vec=8'h0F, en=1 -> q=8'hAA, then 8'hA5; t_vec=0 -> hold; tc stays 0.
- Priority/sticky: clear+load+en in the same cycle -> q=0. With the macro built, after any wrap ovf=1 persists through later loads, and clear -> ovf=0. Without the macro, ovf stays 0 throughout.
